// File: rtl/misr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : misr_pkg
// Description : Shared definitions for the parametrised MISR: FSM state
//               encodings and the default feedback polynomial / seed.
// Revision    : 1.0 - initial release
// ============================================================================
package misr_pkg;

    // Run-control state encoding
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPACT = 2'd1,
        DONE    = 2'd2
    } misr_state_e;

    // Defaults for a 16-bit signature: x^16 + x^12 + x^3 + x^1 + 1
    localparam logic [15:0] C_DEFAULT_POLY = 16'h100B;
    localparam logic [15:0] C_DEFAULT_SEED = 16'h0000;

endpackage : misr_pkg
`default_nettype wire

// File: rtl/misr_step.sv
`default_nettype none
// ============================================================================
// Module      : misr_step
// Description : One combinational Galois MISR/LFSR step.
//               The MSB of the current signature is the feedback bit; it is
//               XORed into every stage whose POLY bit is set, while data_i
//               bit i is XORed into stage i (forced to 0 in LFSR mode).
// Ports       : sig_i       - current signature
//               data_i      - response bits (bit 0 feeds stage 0)
//               mode_lfsr_i - 1: ignore data_i, pure LFSR step
//               next_o      - next signature
// Revision    : 1.0 - initial release
// ============================================================================
module misr_step
    import misr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               IN_WIDTH = 10,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(C_DEFAULT_POLY)
) (
    input  logic [WIDTH-1:0]    sig_i,
    input  logic [IN_WIDTH-1:0] data_i,
    input  logic                mode_lfsr_i,
    output logic [WIDTH-1:0]    next_o
);

    logic             w_fb;
    logic [WIDTH-1:0] w_d;

    assign w_fb = sig_i[WIDTH-1];

    // Data is zero-extended up to WIDTH; stages above IN_WIDTH see no input.
    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_d
            if (i < IN_WIDTH) begin : g_in
                assign w_d[i] = data_i[i] & ~mode_lfsr_i;
            end else begin : g_zero
                assign w_d[i] = 1'b0;
            end
        end
    endgenerate

    assign next_o[0] = (w_fb & POLY[0]) ^ w_d[0];

    generate
        for (genvar i = 1; i < WIDTH; i++) begin : g_stage
            assign next_o[i] = sig_i[i-1] ^ (w_fb & POLY[i]) ^ w_d[i];
        end
    endgenerate

endmodule : misr_step
`default_nettype wire

// File: rtl/param_misr.sv
`default_nettype none
// ============================================================================
// Module      : param_misr
// Description : Parametrised multiple-input signature register with run
//               control (IDLE -> COMPACT -> DONE) and golden comparison.
//               A run compacts exactly CYCLES valid data words, then holds
//               the signature and reports pass/fail against the golden reg.
// Ports       : clock, reset_n (async, active low)
//               start, abort    - run control (abort has priority)
//               mode_lfsr       - 1: ignore data_in
//               data_valid, data_in
//               golden_load, golden_in - expected signature capture
//               signature, busy, done, pass_nfail
// Revision    : 1.0 - initial release
// ============================================================================
module param_misr
    import misr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               IN_WIDTH = 10,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(C_DEFAULT_POLY),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(C_DEFAULT_SEED),
    parameter int               CYCLES   = 1024
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic                abort,
    input  logic                mode_lfsr,
    input  logic                data_valid,
    input  logic [IN_WIDTH-1:0] data_in,
    input  logic                golden_load,
    input  logic [WIDTH-1:0]    golden_in,
    output logic [WIDTH-1:0]    signature,
    output logic                busy,
    output logic                done,
    output logic                pass_nfail
);

    // Wide enough to hold CYCLES itself, so the counter can never wrap.
    localparam int             CW     = $clog2(CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(CYCLES - 1);

    misr_state_e      state_q, state_d;
    logic [WIDTH-1:0] sig_q, sig_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] golden_q;
    logic [WIDTH-1:0] w_step;

    misr_step #(
        .WIDTH    (WIDTH),
        .IN_WIDTH (IN_WIDTH),
        .POLY     (POLY)
    ) u_step (
        .sig_i       (sig_q),
        .data_i      (data_in),
        .mode_lfsr_i (mode_lfsr),
        .next_o      (w_step)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            sig_q    <= SEED;
            cnt_q    <= '0;
            golden_q <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            cnt_q   <= cnt_d;
            if (golden_load) begin
                golden_q <= golden_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        cnt_d   = cnt_q;

        if (abort) begin
            // Abort beats start; signature and counter are left as they are.
            state_d = IDLE;
        end else if (start) begin
            // Restart from any state: no step is taken this cycle.
            state_d = COMPACT;
            sig_d   = SEED;
            cnt_d   = '0;
        end else begin
            case (state_q)
                COMPACT: begin
                    if (data_valid) begin
                        sig_d = w_step;
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == C_LAST) begin
                            state_d = DONE;
                        end
                    end
                end
                IDLE, DONE: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // All outputs come from registers only, so data_in cannot glitch them.
    assign signature  = sig_q;
    assign busy       = (state_q == COMPACT);
    assign done       = (state_q == DONE);
    assign pass_nfail = (state_q == DONE) && (sig_q == golden_q);

endmodule : param_misr
`default_nettype wire

// File: doc/param_misr.md
PARAM_MISR -- requirements
Module: param_misr

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signature width in bits, range 4..64.
REQ-002 SHALL have parameter IN_WIDTH, default 10: compacted data width, 1..WIDTH.
REQ-003 SHALL have parameter POLY, default 16'h100B: WIDTH-bit feedback tap mask, bit i set means tap into stage i.
REQ-004 SHALL have parameter SEED, default 0: WIDTH-bit signature start value.
REQ-005 SHALL have parameter CYCLES, default 1024: number of valid cycles compacted per run, range 1..65535.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all state on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port start, input, 1 bit: begin or restart a run.
REQ-009 SHALL have port abort, input, 1 bit: cancel the run and return to IDLE.
REQ-010 SHALL have port mode_lfsr, input, 1 bit: 1 means data_in is ignored (pure LFSR).
REQ-011 SHALL have port data_valid, input, 1 bit: data_in is compacted this cycle.
REQ-012 SHALL have port data_in, input, IN_WIDTH bits: response bits; bit 0 feeds stage 0.
REQ-013 SHALL have port golden_load, input, 1 bit: capture golden_in into the golden register.
REQ-014 SHALL have port golden_in, input, WIDTH bits: expected signature.
REQ-015 SHALL have port signature, output, WIDTH bits: current signature register.
REQ-016 SHALL have port busy, output, 1 bit: high in COMPACT.
REQ-017 SHALL have port done, output, 1 bit: high in DONE.
REQ-018 SHALL have port pass_nfail, output, 1 bit: done AND (signature == golden); 0 outside DONE.

Function
REQ-019 SHALL implement FSM states IDLE, COMPACT, DONE.
REQ-020 In IDLE, signature SHALL hold; start SHALL load SEED, clear the counter and enter COMPACT next cycle.
REQ-021 Step rule (Galois): fb = sig[WIDTH-1]; next[0] = (fb & POLY[0]) ^ d[0]; next[i] = sig[i-1] ^ (fb & POLY[i]) ^ d[i]; d[i] = data_in[i] for i < IN_WIDTH and mode_lfsr = 0, else 0.
REQ-022 In COMPACT, each data_valid cycle SHALL apply one step and increment the counter; cycles without data_valid SHALL hold the signature and counter.
REQ-023 The valid cycle that raises the count to CYCLES SHALL apply its step and move to DONE; done SHALL be high the following cycle (latency 1).
REQ-024 In DONE, signature SHALL hold, data_valid SHALL be ignored, and start SHALL restart as in IDLE.
REQ-025 start in COMPACT SHALL restart: reload SEED, clear counter, no step that cycle.
REQ-026 abort SHALL force IDLE next cycle from any state, signature held; abort and start together: abort wins.
REQ-027 golden_load SHALL update golden in any state, effective for pass_nfail the next cycle.
REQ-028 The counter SHALL be $clog2(CYCLES+1) bits wide and SHALL never wrap.
REQ-029 pass_nfail SHALL be registered-state derived (combinational from state, signature and golden) with no glitch path from data_in.

Reset
REQ-030 reset_n low SHALL asynchronously set state to IDLE, signature to SEED, counter to 0, golden to 0; busy, done and pass_nfail SHALL read 0.
REQ-031 Reset mid-run SHALL discard the run; no done pulse SHALL follow.

Structure
REQ-032 Package misr_pkg SHALL hold the state encodings (IDLE=2'd0, COMPACT=2'd1, DONE=2'd2) and the default POLY/SEED constants.
REQ-033 One combinational sub-module misr_step SHALL implement REQ-021, parametrised by WIDTH, IN_WIDTH and POLY.

Verification
Use WIDTH=16, IN_WIDTH=10, POLY=16'h100B, SEED=0, CYCLES=4 unless stated.
REQ-034 Zero data: golden 0, start, 4 valid cycles of data_in=0 -> signature 0x0000, done=1 and pass_nfail=1 on the cycle after the 4th valid.
REQ-035 Single bit: data_in=0x001 then three zeros -> signature 0x0001, 0x0002, 0x0004, 0x0008; with golden 0x0000, pass_nfail=0.
REQ-036 Feedback, LFSR mode: SEED=16'h8000, mode_lfsr=1, CYCLES=1, data_in=0x3FF -> signature 0x100B.
REQ-037 Valid gaps and restart: data_valid toggled 1,0,1,0,... -> done only after 4 valid cycles; start asserted on the 3rd valid -> counter restarts from 0 and signature resets to SEED.
REQ-038 Abort and reset: abort with start in COMPACT -> IDLE, busy=0, signature held; reset_n pulsed mid-run -> signature=SEED and done never asserts.
